// File: rtl/assoc_cache.sv
// N-way set-associative write-back cache: tag check, tree-PLRU replacement and flush sequencer.
// Hits answer combinationally; misses stall the requester until the memory fill completes.
module assoc_cache #(
  parameter int s_way    = 2,
  parameter int s_offset = 5,
  parameter int s_index  = 4,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_mask   = 2**s_offset,
  parameter int s_line   = 8*s_mask
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [s_mask-1:0] mem_byte_enable,
  input  logic [s_line-1:0] mem_wdata,
  output logic [s_line-1:0] mem_rdata,
  output logic              mem_resp,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int ways     = 2**s_way;
  localparam int num_sets = 2**s_index;
  localparam int wbits    = (s_way > 0) ? s_way : 1;
  localparam int pbits    = (ways > 1) ? ways - 1 : 1;
  localparam int cbits    = s_index + s_way + 1;

  typedef enum logic [2:0] {IDLE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB} state_t;

  state_t state_q, state_d;

  logic [s_tag-1:0]  tag_q   [num_sets][ways];
  logic [s_line-1:0] data_q  [num_sets][ways];
  logic [ways-1:0]   valid_q [num_sets];
  logic [ways-1:0]   valid_d [num_sets];
  logic [ways-1:0]   dirty_q [num_sets];
  logic [ways-1:0]   dirty_d [num_sets];
  logic [pbits-1:0]  plru_q  [num_sets];
  logic [pbits-1:0]  plru_d  [num_sets];

  logic [wbits-1:0]   victim_q, victim_d;
  logic [s_tag-1:0]   req_tag_q, req_tag_d;
  logic [s_index-1:0] req_idx_q, req_idx_d;
  logic [cbits-1:0]   flush_cnt_q, flush_cnt_d;

  logic [s_tag-1:0]   req_tag;
  logic [s_index-1:0] req_idx;
  logic               hit, any_inv;
  logic [wbits-1:0]   hit_way, inv_way, victim;
  logic [s_index-1:0] flush_set;
  logic [wbits-1:0]   flush_way;
  logic               flush_end;
  logic               data_we, tag_we;
  logic [s_index-1:0] wr_set;
  logic [wbits-1:0]   wr_way;
  logic [s_line-1:0]  data_wd;
  logic               unused_offset;

  assign req_tag       = mem_address[31 -: s_tag];
  assign req_idx       = mem_address[s_offset +: s_index];
  assign unused_offset = ^mem_address[s_offset-1:0];
  assign flush_set     = flush_cnt_q[s_way +: s_index];
  assign flush_way     = wbits'(flush_cnt_q & cbits'(ways - 1));
  assign flush_end     = flush_cnt_q[cbits-1];
  assign mem_rdata     = data_q[req_idx][hit_way];

  // Walk from the root: a 0 bit sends the search left, a 1 bit right.
  function automatic logic [wbits-1:0] plru_victim(input logic [pbits-1:0] p);
    logic [wbits-1:0] v;
    logic [pbits-1:0] sh;
    int node;
    v    = '0;
    node = 0;
    for (int l = 0; l < s_way; l++) begin
      sh   = p >> node;
      v    = (v << 1) | wbits'(sh[0]);
      node = 2*node + (sh[0] ? 2 : 1);
    end
    return v;
  endfunction

  function automatic logic [pbits-1:0] plru_touch(input logic [pbits-1:0] p, input logic [wbits-1:0] way);
    logic [pbits-1:0] r;
    logic [wbits-1:0] ws;
    int node;
    r    = p;
    node = 0;
    for (int l = 0; l < s_way; l++) begin
      ws = way >> (s_way - 1 - l);
      if (ws[0]) r = r & ~(pbits'(1) << node);
      else       r = r |  (pbits'(1) << node);
      node = 2*node + (ws[0] ? 2 : 1);
    end
    return r;
  endfunction

  function automatic logic [s_line-1:0] merge_bytes(input logic [s_line-1:0] old_line,
                                                    input logic [s_line-1:0] new_line,
                                                    input logic [s_mask-1:0] be);
    logic [s_line-1:0] r;
    for (int b = 0; b < s_mask; b++)
      r[8*b +: 8] = be[b] ? new_line[8*b +: 8] : old_line[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < ways; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = wbits'(w);
      end
    end
  end

  // Invalid ways are always preferred; the downward scan leaves the lowest one.
  always_comb begin
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = ways - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        any_inv = 1'b1;
        inv_way = wbits'(w);
      end
    end
    victim = any_inv ? inv_way : plru_victim(plru_q[req_idx]);
  end

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    req_tag_d    = req_tag_q;
    req_idx_d    = req_idx_q;
    flush_cnt_d  = flush_cnt_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    plru_d       = plru_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    wr_set       = req_idx;
    wr_way       = hit_way;
    data_wd      = merge_bytes(data_q[req_idx][hit_way], mem_wdata, mem_byte_enable);
    mem_resp     = 1'b0;
    flush_done   = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (hit) begin
            mem_resp        = 1'b1;
            plru_d[req_idx] = plru_touch(plru_q[req_idx], hit_way);
            if (mem_write) begin
              data_we                   = 1'b1;
              dirty_d[req_idx][hit_way] = 1'b1;
            end
          end else begin
            victim_d  = victim;
            req_tag_d = req_tag;
            req_idx_d = req_idx;
            state_d   = (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ? WRITEBACK : ALLOCATE;
          end
        end else if (flush_req) begin
          flush_cnt_d = '0;
          state_d     = FLUSH_SCAN;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[req_idx_q][victim_q], req_idx_q, {s_offset{1'b0}}};
        pmem_wdata   = data_q[req_idx_q][victim_q];
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag_q, req_idx_q, {s_offset{1'b0}}};
        if (pmem_resp) begin
          data_we                      = 1'b1;
          tag_we                       = 1'b1;
          wr_set                       = req_idx_q;
          wr_way                       = victim_q;
          data_wd                      = pmem_rdata;
          valid_d[req_idx_q][victim_q] = 1'b1;
          dirty_d[req_idx_q][victim_q] = 1'b0;
          state_d                      = IDLE;
        end
      end
      FLUSH_SCAN: begin
        if (flush_end) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end else if (valid_q[flush_set][flush_way] && dirty_q[flush_set][flush_way]) begin
          state_d = FLUSH_WB;
        end else begin
          flush_cnt_d = flush_cnt_q + cbits'(1);
        end
      end
      FLUSH_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[flush_set][flush_way], flush_set, {s_offset{1'b0}}};
        pmem_wdata   = data_q[flush_set][flush_way];
        if (pmem_resp) begin
          dirty_d[flush_set][flush_way] = 1'b0;
          flush_cnt_d                   = flush_cnt_q + cbits'(1);
          state_d                       = FLUSH_SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      victim_q    <= '0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      flush_cnt_q <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      flush_cnt_q <= flush_cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      plru_q      <= plru_d;
    end
  end

  // Tag and data carry no reset; valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (data_we) data_q[wr_set][wr_way] <= data_wd;
    if (tag_we)  tag_q[wr_set][wr_way]  <= req_tag_q;
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed scenarios plus a randomized phase for assoc_cache (4-way, 16 sets, 32-byte lines),
// checked against a behavioural cache and memory model.
module tb_assoc_cache;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_byte_enable = '0;
  logic [255:0] mem_wdata = '0;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         flush_req = 1'b0;
  logic         flush_done;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  always #5 clk = ~clk;

  assoc_cache dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .flush_req(flush_req), .flush_done(flush_done),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: cache contents, tree bits per set, backing memory.
  bit           m_valid [16][4];
  bit           m_dirty [16][4];
  logic [22:0]  m_tag   [16][4];
  logic [255:0] m_data  [16][4];
  bit           m_tree  [16][3];
  logic [255:0] pmem_store [logic [31:0]];

  int           last_nrd, last_nwb, flush_cycles;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  last_wb_addr = '0;
  logic [255:0] last_wb_data = '0;
  logic [31:0]  flush_log [$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int t, input int s);
    return (32'(t) << 9) | (32'(s) << 5);
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (pmem_store.exists(a)) return pmem_store[a];
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      for (int n = 0; n < 3; n++) m_tree[s][n] = 1'b0;
    end
  endtask

  function automatic int find_hit(input int s, input logic [22:0] t);
    for (int w = 0; w < 4; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  // Level l node on the path to way w is (2^l - 1) + (w >> (2-l)); its direction is bit (1-l) of w.
  function automatic int pick_victim(input int s);
    int w;
    for (int i = 0; i < 4; i++) if (!m_valid[s][i]) return i;
    w = 0;
    for (int l = 0; l < 2; l++) w = w * 2 + int'(m_tree[s][(1 << l) - 1 + w]);
    return w;
  endfunction

  task automatic touch(input int s, input int w);
    for (int l = 0; l < 2; l++)
      m_tree[s][(1 << l) - 1 + (w >> (2 - l))] = (((w >> (1 - l)) & 1) == 0);
  endtask

  task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] be, input logic [255:0] wd);
    int s, w, iters, waits, nwb, nrd, wcnt;
    bit hit, dv, got;
    logic [22:0]  t;
    logic [31:0]  line_addr, exp_wb_addr;
    logic [255:0] exp_wb_data;
    s = int'(addr[8:5]);
    t = addr[31:9];
    line_addr = {addr[31:5], 5'b0};
    w = find_hit(s, t);
    hit = (w >= 0);
    dv = 1'b0;
    exp_wb_addr = '0;
    exp_wb_data = '0;
    if (!hit) begin
      w = pick_victim(s);
      dv = m_valid[s][w] && m_dirty[s][w];
      exp_wb_addr = {m_tag[s][w], addr[8:5], 5'b0};
      exp_wb_data = m_data[s][w];
    end
    mem_address     = addr;
    mem_write       = wr;
    mem_read        = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_byte_enable = be;
    mem_wdata       = wd;
    waits = 0; nwb = 0; nrd = 0; got = 1'b0; iters = 0;
    wcnt = $urandom_range(0, 3);
    for (int i = 1; i <= 300; i++) begin
      iters = i;
      @(negedge clk);
      pmem_resp = 1'b0;
      if (mem_resp) begin
        got = 1'b1;
        break;
      end
      if (pmem_write || pmem_read) begin
        if (wcnt > 0) begin
          wcnt--;
          waits++;
        end else begin
          if (pmem_write) begin
            nwb++;
            chk("wb_addr", pmem_address, exp_wb_addr);
            chk("wb_data", pmem_wdata, exp_wb_data);
            pmem_store[pmem_address] = pmem_wdata;
            last_wb_addr = pmem_address;
            last_wb_data = pmem_wdata;
          end else begin
            nrd++;
            chk("fill_addr", pmem_address, line_addr);
            last_rd_addr = pmem_address;
            pmem_rdata = mem_line(pmem_address);
          end
          pmem_resp = 1'b1;
          wcnt = $urandom_range(0, 3);
        end
      end
    end
    if (!hit) begin
      m_valid[s][w] = 1'b1;
      m_dirty[s][w] = 1'b0;
      m_tag[s][w]   = t;
      m_data[s][w]  = mem_line(line_addr);
    end
    touch(s, w);
    if (wr) begin
      for (int b = 0; b < 32; b++)
        if (be[b]) m_data[s][w][8*b +: 8] = wd[8*b +: 8];
      m_dirty[s][w] = 1'b1;
    end
    chk("resp_seen", 256'(got), 256'(1));
    if (!wr) chk("rdata", mem_rdata, m_data[s][w]);
    chk("n_writeback", 256'(nwb), 256'((!hit && dv) ? 1 : 0));
    chk("n_fill", 256'(nrd), 256'(hit ? 0 : 1));
    chk("latency", 256'(iters), 256'(hit ? 1 : 3 + waits + (dv ? 1 : 0)));
    last_nrd = nrd;
    last_nwb = nwb;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_flush();
    logic [31:0]  exp_a [$];
    logic [255:0] exp_d [$];
    int n, nrd, wcnt, iters;
    bit got;
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          exp_a.push_back({m_tag[s][w], 4'(s), 5'b0});
          exp_d.push_back(m_data[s][w]);
        end
    flush_log.delete();
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    n = 0; nrd = 0; got = 1'b0; iters = 0;
    wcnt = $urandom_range(0, 2);
    for (int i = 1; i <= 3000; i++) begin
      iters = i;
      @(negedge clk);
      pmem_resp = 1'b0;
      if (flush_done) begin
        got = 1'b1;
        break;
      end
      if (pmem_read) begin
        nrd++;
        pmem_rdata = mem_line(pmem_address);
        pmem_resp = 1'b1;
      end else if (pmem_write) begin
        if (wcnt > 0) wcnt--;
        else begin
          if (n < exp_a.size()) begin
            chk("flush_wb_addr", pmem_address, exp_a[n]);
            chk("flush_wb_data", pmem_wdata, exp_d[n]);
          end
          flush_log.push_back(pmem_address);
          pmem_store[pmem_address] = pmem_wdata;
          n++;
          pmem_resp = 1'b1;
          wcnt = $urandom_range(0, 2);
        end
      end
    end
    flush_cycles = iters;
    chk("flush_done_seen", 256'(got), 256'(1));
    chk("flush_n_wb", 256'(n), 256'(exp_a.size()));
    chk("flush_no_reads", 256'(nrd), 256'(0));
    @(negedge clk);
    chk("flush_done_pulse", 256'(flush_done), 256'(0));
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) m_dirty[s][w] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] wd;
    bit seen;
    model_reset();

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_resp", 256'(mem_resp), 256'(0));
    chk("rst_flush_done", 256'(flush_done), 256'(0));
    chk("rst_pmem_read", 256'(pmem_read), 256'(0));
    chk("rst_pmem_write", 256'(pmem_write), 256'(0));
    chk("rst_pmem_addr", 256'(pmem_address), 256'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold read, then a repeat hit
    do_op(1'b0, 32'h0000_1040, '0, '0);
    chk("cold_fill_addr", 256'(last_rd_addr), 256'(32'h0000_1040));
    do_op(1'b0, 32'h0000_1044, '0, '0);
    chk("repeat_is_hit", 256'(last_nrd), 256'(0));

    // Masked write to the resident line, then four more tags in set 2 evict it
    wd = {224'h0, 32'hDEAD_BEEF};
    do_op(1'b1, 32'h0000_1040, 32'h0000_000F, wd);
    for (int t = 1; t <= 4; t++) do_op(1'b0, mk(t, 2), '0, '0);
    chk("evict_wb_addr", 256'(last_wb_addr), 256'(32'h0000_1040));
    chk("evict_wb_bytes", 256'(last_wb_data[31:0]), 256'(32'hDEAD_BEEF));

    // PLRU order in set 5: fill ways 0..3 dirty, touch 0,2,1
    for (int t = 1; t <= 4; t++) do_op(1'b1, mk(t, 5), 32'hFFFF_FFFF, {8{$urandom}});
    do_op(1'b0, mk(1, 5), '0, '0);
    do_op(1'b0, mk(3, 5), '0, '0);
    do_op(1'b0, mk(2, 5), '0, '0);
    do_op(1'b0, mk(5, 5), '0, '0);
    chk("plru_first_victim", 256'(last_wb_addr), 256'(mk(4, 5)));
    do_op(1'b0, mk(6, 5), '0, '0);
    chk("plru_second_victim", 256'(last_wb_addr), 256'(mk(1, 5)));

    // Flush with dirty (set 2, way 1) and (set 9, way 3)
    do_reset();
    do_op(1'b0, mk(1, 2), '0, '0);
    do_op(1'b1, mk(2, 2), 32'hFFFF_FFFF, {8{$urandom}});
    for (int t = 1; t <= 3; t++) do_op(1'b0, mk(t, 9), '0, '0);
    do_op(1'b1, mk(4, 9), 32'h00FF_00FF, {8{$urandom}});
    do_flush();
    chk("flush_count", 256'(flush_log.size()), 256'(2));
    if (flush_log.size() == 2) begin
      chk("flush_first", 256'(flush_log[0]), 256'(mk(2, 2)));
      chk("flush_second", 256'(flush_log[1]), 256'(mk(4, 9)));
    end
    do_flush();
    chk("reflush_count", 256'(flush_log.size()), 256'(0));
    chk("clean_flush_cycles", 256'(flush_cycles), 256'(65));
    do_op(1'b0, mk(4, 9), '0, '0);
    chk("flush_keeps_valid", 256'(last_nrd), 256'(0));

    // flush_req together with a read miss: the read is served first
    do_op(1'b1, mk(1, 4), 32'hFFFF_FFFF, {8{$urandom}});
    flush_req = 1'b1;
    do_op(1'b0, mk(7, 12), '0, '0);
    do_flush();
    chk("collision_flush_count", 256'(flush_log.size()), 256'(1));

    // Reset while a dirty victim is being written back
    for (int t = 1; t <= 4; t++) do_op(1'b1, mk(t, 7), 32'hFFFF_FFFF, {8{$urandom}});
    mem_address = mk(9, 7);
    mem_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_write) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_wb_seen", 256'(seen), 256'(1));
    rst = 1'b0;
    mem_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_pmem_write", 256'(pmem_write), 256'(0));
    chk("abort_pmem_read", 256'(pmem_read), 256'(0));
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_op(1'b0, mk(1, 7), '0, '0);
    chk("abort_then_miss", 256'(last_nrd), 256'(1));

    // Randomized traffic over a few sets and a small tag pool
    for (int k = 0; k < 180; k++) begin
      int sets [3] = '{0, 3, 11};
      do_op(1'($urandom_range(0, 1)), mk($urandom_range(1, 6), sets[$urandom_range(0, 2)]),
            $urandom, {8{$urandom}});
      if (k % 60 == 59) do_flush();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
